// File: rtl/stack_arbiter.sv
// Round-robin arbiter that shares one LIFO stack between requesters A and B,
// running each push/pop as an ISSUE/WAIT/RESP transaction with local overflow/underflow guarding.
module stack_arbiter #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 1,
    parameter int CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    // Requester handshake: req/op/wdata are held stable until the one-cycle gnt
    // pulse; the matching response later arrives as a one-cycle rsp_valid pulse.
    input  logic                  a_req,
    input  logic                  a_op,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_gnt,
    input  logic                  b_req,
    input  logic                  b_op,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_gnt,
    output logic                  rsp_valid,
    output logic                  rsp_id,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_error,
    output logic                  stk_push,
    output logic                  stk_pop,
    output logic [DATA_WIDTH-1:0] stk_data_in,
    input  logic [DATA_WIDTH-1:0] stk_data_out,
    input  logic                  stk_error,
    output logic [CNT_W-1:0]      count,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  rr_q, rr_d;
    logic                  win_q, win_d;
    logic                  op_q, op_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  refused_q, refused_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [1:0]            wait_q, wait_d;
    logic                  a_gnt_q, a_gnt_d;
    logic                  b_gnt_q, b_gnt_d;

    logic                  push_c, pop_c, rsp_valid_c, rsp_id_c, rsp_error_c;
    logic [DATA_WIDTH-1:0] din_c, rsp_data_c;
    logic                  win_c, refused_c;

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        win_d       = win_q;
        op_d        = op_q;
        data_d      = data_q;
        refused_d   = refused_q;
        count_d     = count_q;
        wait_d      = wait_q;
        a_gnt_d     = 1'b0;
        b_gnt_d     = 1'b0;
        push_c      = 1'b0;
        pop_c       = 1'b0;
        din_c       = '0;
        rsp_valid_c = 1'b0;
        rsp_id_c    = 1'b0;
        rsp_data_c  = '0;
        rsp_error_c = 1'b0;
        win_c       = 1'b0;
        refused_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (a_req || b_req) begin
                    // Contended picks go to the pointer, which then moves to the loser.
                    win_c   = (a_req && b_req) ? rr_q : b_req;
                    win_d   = win_c;
                    op_d    = win_c ? b_op : a_op;
                    data_d  = win_c ? b_wdata : a_wdata;
                    rr_d    = (a_req && b_req) ? ~rr_q : rr_q;
                    a_gnt_d = ~win_c;
                    b_gnt_d = win_c;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                refused_c = op_q ? (count_q == '0) : (count_q == CNT_W'(DEPTH));
                refused_d = refused_c;
                if (!refused_c) begin
                    if (op_q) begin
                        pop_c   = 1'b1;
                        count_d = count_q - CNT_W'(1);
                    end else begin
                        push_c  = 1'b1;
                        din_c   = data_q;
                        count_d = count_q + CNT_W'(1);
                    end
                end
                wait_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (!op_q && !refused_q) din_c = data_q;
                if (wait_q == 2'(WAIT_CYCLES - 1)) state_d = RESP;
                else wait_d = wait_q + 2'd1;
            end
            RESP: begin
                rsp_valid_c = 1'b1;
                rsp_id_c    = win_q;
                rsp_data_c  = (op_q && !refused_q) ? stk_data_out : '0;
                rsp_error_c = refused_q | stk_error;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            rr_q      <= 1'b0;
            win_q     <= 1'b0;
            op_q      <= 1'b0;
            data_q    <= '0;
            refused_q <= 1'b0;
            count_q   <= '0;
            wait_q    <= '0;
            a_gnt_q   <= 1'b0;
            b_gnt_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            win_q     <= win_d;
            op_q      <= op_d;
            data_q    <= data_d;
            refused_q <= refused_d;
            count_q   <= count_d;
            wait_q    <= wait_d;
            a_gnt_q   <= a_gnt_d;
            b_gnt_q   <= b_gnt_d;
        end
    end

    // Outputs are forced low for the whole reset cycle, even mid-transaction.
    always_comb begin
        a_gnt       = a_gnt_q & ~reset;
        b_gnt       = b_gnt_q & ~reset;
        rsp_valid   = rsp_valid_c & ~reset;
        rsp_id      = rsp_id_c & ~reset;
        rsp_data    = reset ? '0 : rsp_data_c;
        rsp_error   = rsp_error_c & ~reset;
        stk_push    = push_c & ~reset;
        stk_pop     = pop_c & ~reset;
        stk_data_in = reset ? '0 : din_c;
        count       = reset ? '0 : count_q;
        dbg_state   = reset ? 2'd0 : state_q;
    end

endmodule

// File: tb/tb_stack_arbiter.sv
// Bench for stack_arbiter: emulates the stack, drives both requesters and checks
// every response against a queue-based model of the shared LIFO and round-robin rule.
module tb_stack_arbiter;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int WAITC = 1;
    localparam int LAT   = 2 + WAITC;

    logic          clk = 1'b0;
    logic          reset;
    logic          a_req, a_op, b_req, b_op;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_gnt, b_gnt, rsp_valid, rsp_id, rsp_error;
    logic [DW-1:0] rsp_data, stk_data_in;
    logic [DW-1:0] stk_data_out = '0;
    logic          stk_push, stk_pop;
    logic          stk_error = 1'b0;
    logic [4:0]    count;
    logic [1:0]    dbg_state;

    int            cyc = 0;
    int            push_cnt = 0, pop_cnt = 0, both_cnt = 0;
    int            chk_cnt = 0, pass_cnt = 0;
    logic [DW-1:0] env_stk[$];
    logic [DW-1:0] exp_q[$];
    bit            exp_rr = 1'b0;

    stack_arbiter #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .WAIT_CYCLES(WAITC)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_op(a_op), .a_wdata(a_wdata), .a_gnt(a_gnt),
        .b_req(b_req), .b_op(b_op), .b_wdata(b_wdata), .b_gnt(b_gnt),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_error(rsp_error),
        .stk_push(stk_push), .stk_pop(stk_pop), .stk_data_in(stk_data_in),
        .stk_data_out(stk_data_out), .stk_error(stk_error),
        .count(count), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Behavioural stack on the far side of the arbiter.
    always @(posedge clk) begin
        cyc++;
        if (stk_push && stk_pop) both_cnt++;
        if (stk_push) begin
            push_cnt++;
            env_stk.push_back(stk_data_in);
        end
        if (stk_pop) begin
            pop_cnt++;
            if (env_stk.size() > 0) stk_data_out = env_stk.pop_back();
        end
    end

    task automatic do_txn(input bit who, input bit op, input logic [DW-1:0] data,
                          output bit rid, output logic [DW-1:0] rdata, output bit rerr,
                          output int lat, output bit to);
        int t;
        int g_cyc;
        to = 1'b0; rid = 1'b0; rdata = '0; rerr = 1'b0; lat = 0;
        if (!who) begin a_req = 1'b1; a_op = op; a_wdata = data; end
        else begin b_req = 1'b1; b_op = op; b_wdata = data; end
        t = 0;
        do begin @(negedge clk); t++; end while (!(who ? b_gnt : a_gnt) && t < 30);
        if (!who) a_req = 1'b0; else b_req = 1'b0;
        if (!(who ? b_gnt : a_gnt)) begin to = 1'b1; return; end
        g_cyc = cyc;
        t = 0;
        do begin @(negedge clk); t++; end while (!rsp_valid && t < 30);
        if (!rsp_valid) begin to = 1'b1; return; end
        rid = rsp_id; rdata = rsp_data; rerr = rsp_error;
        lat = cyc - g_cyc + 1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk_cnt++; if (count !== 5'd0) $display("FAIL reset_count: got %0d want 0", count); else pass_cnt++;
        chk_cnt++; if ({a_gnt, b_gnt, rsp_valid, rsp_error, stk_push, stk_pop} !== 6'b0)
            $display("FAIL reset_strobes: got %b want 000000", {a_gnt, b_gnt, rsp_valid, rsp_error, stk_push, stk_pop});
        else pass_cnt++;
        chk_cnt++; if ({rsp_data, stk_data_in} !== 16'h0)
            $display("FAIL reset_data: got %h want 0000", {rsp_data, stk_data_in}); else pass_cnt++;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk_cnt++; if (count !== 5'd0) $display("FAIL post_reset_count: got %0d want 0", count); else pass_cnt++;
    endtask

    task automatic test_fill;
        bit rid, rerr, to;
        logic [DW-1:0] rdata;
        int lat;
        for (int i = 0; i < DEPTH; i++) begin
            do_txn(1'b0, 1'b0, DW'(i), rid, rdata, rerr, lat, to);
            chk_cnt++; if (to) begin $display("FAIL fill_timeout: push %0d got no response", i); continue; end else pass_cnt++;
            exp_q.push_back(DW'(i));
            chk_cnt++; if ({rid, rerr, rdata} !== 10'h0)
                $display("FAIL fill_rsp: push %0d got id/err/data %0d/%0d/%h want 0/0/00", i, rid, rerr, rdata); else pass_cnt++;
            chk_cnt++; if (lat !== LAT) $display("FAIL fill_latency: got %0d want %0d", lat, LAT); else pass_cnt++;
        end
        chk_cnt++; if (count !== 5'(exp_q.size())) $display("FAIL fill_count: got %0d want %0d", count, exp_q.size()); else pass_cnt++;
    endtask

    task automatic test_overflow;
        bit rid, rerr, to;
        logic [DW-1:0] rdata;
        int lat, p0;
        p0 = push_cnt;
        do_txn(1'b0, 1'b0, 8'hAA, rid, rdata, rerr, lat, to);
        chk_cnt++; if (to || rerr !== 1'b1) $display("FAIL overflow_err: got err %0d timeout %0d want err 1", rerr, to); else pass_cnt++;
        chk_cnt++; if (rdata !== 8'h00) $display("FAIL overflow_data: got %h want 00", rdata); else pass_cnt++;
        chk_cnt++; if (push_cnt !== p0) $display("FAIL overflow_strobe: got %0d pushes want 0", push_cnt - p0); else pass_cnt++;
        chk_cnt++; if (count !== 5'd16) $display("FAIL overflow_count: got %0d want 16", count); else pass_cnt++;
    endtask

    task automatic test_drain;
        bit rid, rerr, to;
        logic [DW-1:0] rdata, exp;
        int lat, p0;
        for (int i = 0; i < DEPTH; i++) begin
            do_txn(1'b1, 1'b1, '0, rid, rdata, rerr, lat, to);
            exp = exp_q.pop_back();
            chk_cnt++; if (to || rdata !== exp) $display("FAIL drain_data: pop %0d got %h want %h", i, rdata, exp); else pass_cnt++;
            chk_cnt++; if (rid !== 1'b1 || rerr !== 1'b0) $display("FAIL drain_rsp: got id/err %0d/%0d want 1/0", rid, rerr); else pass_cnt++;
        end
        p0 = pop_cnt;
        do_txn(1'b1, 1'b1, '0, rid, rdata, rerr, lat, to);
        chk_cnt++; if (to || rerr !== 1'b1) $display("FAIL underflow_err: got err %0d timeout %0d want err 1", rerr, to); else pass_cnt++;
        chk_cnt++; if (pop_cnt !== p0) $display("FAIL underflow_strobe: got %0d pops want 0", pop_cnt - p0); else pass_cnt++;
        chk_cnt++; if (count !== 5'd0 || rdata !== 8'h00) $display("FAIL underflow_state: got count %0d data %h want 0 00", count, rdata); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int t;
        bit w;
        a_req = 1'b1; a_op = 1'b0; a_wdata = DW'($urandom);
        b_req = 1'b1; b_op = 1'b0; b_wdata = DW'($urandom);
        for (int g = 0; g < 6; g++) begin
            t = 0;
            while (!a_gnt && !b_gnt && t < 30) begin @(negedge clk); t++; end
            chk_cnt++; if (!a_gnt && !b_gnt) begin $display("FAIL rr_timeout: grant %0d never arrived", g); break; end else pass_cnt++;
            w = b_gnt;
            chk_cnt++; if (w !== exp_rr || (a_gnt && b_gnt)) $display("FAIL rr_order: grant %0d got %0d want %0d", g, w, exp_rr); else pass_cnt++;
            exp_q.push_back(w ? b_wdata : a_wdata);
            exp_rr = ~exp_rr;
            if (w) b_wdata = DW'($urandom); else a_wdata = DW'($urandom);
            t = 0;
            do begin @(negedge clk); t++; end while (!rsp_valid && t < 30);
            chk_cnt++; if (!rsp_valid || rsp_id !== w || rsp_error !== 1'b0)
                $display("FAIL rr_rsp: grant %0d got valid/id/err %0d/%0d/%0d want 1/%0d/0", g, rsp_valid, rsp_id, rsp_error, w);
            else pass_cnt++;
        end
        a_req = 1'b0; b_req = 1'b0;
        chk_cnt++; if (count !== 5'(exp_q.size())) $display("FAIL rr_count: got %0d want %0d", count, exp_q.size()); else pass_cnt++;
    endtask

    task automatic test_latency;
        bit rid, rerr, to;
        logic [DW-1:0] rdata;
        int lat;
        do_txn(1'b0, 1'b0, 8'hFF, rid, rdata, rerr, lat, to);
        exp_q.push_back(8'hFF);
        chk_cnt++; if (to || lat !== LAT || rerr !== 1'b0) $display("FAIL lat_push: got lat %0d err %0d want %0d 0", lat, rerr, LAT); else pass_cnt++;
        do_txn(1'b0, 1'b1, '0, rid, rdata, rerr, lat, to);
        void'(exp_q.pop_back());
        chk_cnt++; if (to || lat !== LAT) $display("FAIL lat_pop: got %0d want %0d", lat, LAT); else pass_cnt++;
        chk_cnt++; if (rdata !== 8'hFF || rerr !== 1'b0) $display("FAIL lat_pop_data: got %h err %0d want ff 0", rdata, rerr); else pass_cnt++;
    endtask

    task automatic test_random;
        bit who, op, rid, rerr, to, exp_err;
        logic [DW-1:0] data, rdata, exp_data;
        int lat;
        for (int n = 0; n < 40; n++) begin
            who  = 1'($urandom_range(0, 1));
            op   = 1'($urandom_range(0, 1));
            data = DW'($urandom);
            exp_data = '0;
            if (op) begin
                exp_err = (exp_q.size() == 0);
                if (!exp_err) exp_data = exp_q.pop_back();
            end else begin
                exp_err = (exp_q.size() == DEPTH);
                if (!exp_err) exp_q.push_back(data);
            end
            do_txn(who, op, data, rid, rdata, rerr, lat, to);
            chk_cnt++; if (to || {rid, rerr, rdata} !== {who, exp_err, exp_data})
                $display("FAIL rand_rsp: txn %0d got id/err/data %0d/%0d/%h want %0d/%0d/%h", n, rid, rerr, rdata, who, exp_err, exp_data);
            else pass_cnt++;
            chk_cnt++; if (count !== 5'(exp_q.size())) $display("FAIL rand_count: txn %0d got %0d want %0d", n, count, exp_q.size()); else pass_cnt++;
        end
        chk_cnt++; if (both_cnt !== 0) $display("FAIL strobe_overlap: got %0d want 0", both_cnt); else pass_cnt++;
    endtask

    task automatic test_stk_error;
        bit rid, rerr, to, op;
        logic [DW-1:0] rdata, exp_data;
        int lat;
        op = (exp_q.size() == DEPTH);
        exp_data = '0;
        if (op) exp_data = exp_q.pop_back(); else exp_q.push_back(8'h5A);
        stk_error = 1'b1;
        do_txn(1'b1, op, 8'h5A, rid, rdata, rerr, lat, to);
        stk_error = 1'b0;
        chk_cnt++; if (to || rerr !== 1'b1 || rdata !== exp_data)
            $display("FAIL stkerr_rsp: got err %0d data %h want 1 %h", rerr, rdata, exp_data); else pass_cnt++;
        chk_cnt++; if (count !== 5'(exp_q.size())) $display("FAIL stkerr_count: got %0d want %0d", count, exp_q.size()); else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        bit rid, rerr, to, seen;
        logic [DW-1:0] rdata;
        int lat, t;
        a_req = 1'b1; a_op = 1'b0; a_wdata = 8'h33;
        t = 0;
        do begin @(negedge clk); t++; end while (!a_gnt && t < 30);
        a_req = 1'b0;
        chk_cnt++; if (!a_gnt) $display("FAIL rstmid_gnt: got no grant want grant"); else pass_cnt++;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_cnt++; if (count === 5'd0 && stk_data_in === 8'h00) pass_cnt++;
        else $display("FAIL rstmid_outputs: got count %0d din %h want 0 00", count, stk_data_in);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        env_stk.delete(); exp_q.delete(); exp_rr = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        chk_cnt++; if (seen !== 1'b0) $display("FAIL rstmid_rsp: got rsp_valid 1 want 0"); else pass_cnt++;
        chk_cnt++; if (count !== 5'd0) $display("FAIL rstmid_count: got %0d want 0", count); else pass_cnt++;
        do_txn(1'b0, 1'b0, 8'h44, rid, rdata, rerr, lat, to);
        chk_cnt++; if (to || rerr !== 1'b0 || count !== 5'd1)
            $display("FAIL rstmid_push: got err %0d count %0d want 0 1", rerr, count); else pass_cnt++;
    endtask

    initial begin
        reset = 1'b1;
        a_req = 1'b0; a_op = 1'b0; a_wdata = '0;
        b_req = 1'b0; b_op = 1'b0; b_wdata = '0;
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_back_to_back();
        test_latency();
        test_random();
        test_stk_error();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
